// File: rtl/tq_pkg.sv
// rtl/tq_pkg.sv - TU size encodings, row-count helper and merge FSM state type
package tq_pkg;

    localparam logic [1:0] TU4  = 2'd0;
    localparam logic [1:0] TU8  = 2'd1;
    localparam logic [1:0] TU16 = 2'd2;
    localparam logic [1:0] TU32 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } merge_state_t;

    function automatic logic [5:0] rows_of(input logic [1:0] size);
        return 6'd4 << size;
    endfunction

endpackage

// File: rtl/dct_out_merge_if.sv
// rtl/dct_out_merge_if.sv - row collection / merged row stream bundle for dct_out_merge
interface dct_out_merge_if #(
    parameter int DATA_W = 512
);
    logic              i_start;
    logic              i_inverse;
    logic [1:0]        i_size;
    logic              i_valid0;
    logic [DATA_W-1:0] i_data0;
    logic              i_valid1;
    logic [DATA_W-1:0] i_data1;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              o_afull;
    logic              o_busy;
    logic              o_ovf;
    logic              o_err;

    // master drives the compute-side inputs and ready, slave is the merge block
    modport master (
        output i_start, i_inverse, i_size, i_valid0, i_data0, i_valid1, i_data1, i_ready,
        input  o_valid, o_data, o_last, o_afull, o_busy, o_ovf, o_err
    );

    modport slave (
        input  i_start, i_inverse, i_size, i_valid0, i_data0, i_valid1, i_data1, i_ready,
        output o_valid, o_data, o_last, o_afull, o_busy, o_ovf, o_err
    );
endinterface

// File: rtl/dct_merge_fifo.sv
// rtl/dct_merge_fifo.sv - small synchronous FIFO with registered head and occupancy flags
module dct_merge_fifo #(
    parameter int W        = 513,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         full,
    output logic         afull
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // caller guarantees push only when not full or popping in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign valid     = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign afull     = (cnt >= CW'(AF_LEVEL));
    assign head_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dct_out_merge.sv
// rtl/dct_out_merge.sv - merges inverse/forward transform rows into one buffered row stream
// Optional DCT_MERGE_CHK_EN enables the sticky protocol error flag o_err.
module dct_out_merge
    import tq_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_LEVEL   = 2
) (
    input  logic            clk,
    input  logic            rst,
    dct_out_merge_if.slave  bus
);
    merge_state_t      state;
    logic              mode_inv;
    logic [1:0]        size_q;
    logic [4:0]        row_cnt;
    logic              ovf_q;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              collecting;
    logic              push_req;
    logic              push_ok;
    logic              is_last;
    logic [4:0]        last_idx;
    logic              pop;
    logic              fifo_valid;
    logic              fifo_full;
    logic              fifo_afull;
    logic [DATA_W:0]   fifo_head;

    assign sel_valid  = mode_inv ? bus.i_valid0 : bus.i_valid1;
    assign sel_data   = mode_inv ? bus.i_data0  : bus.i_data1;
    assign collecting = (state == COLLECT);
    assign push_req   = collecting & sel_valid;
    assign last_idx   = 5'(rows_of(size_q) - 6'd1);
    assign is_last    = (row_cnt == last_idx);
    assign pop        = fifo_valid & bus.i_ready;
    assign push_ok    = push_req & (~fifo_full | pop);

    dct_merge_fifo #(
        .W        (DATA_W + 1),
        .DEPTH    (FIFO_DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data ({is_last, sel_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .afull     (fifo_afull)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_inv <= 1'b0;
            size_q   <= TU4;
            row_cnt  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state    <= COLLECT;
                        mode_inv <= bus.i_inverse;
                        size_q   <= bus.i_size;
                        row_cnt  <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (push_req) begin
                        if (!push_ok) ovf_q <= 1'b1;
                        if (is_last) begin
                            // a dropped last row can never pop, so skip the drain wait
                            state <= push_ok ? DRAIN : IDLE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head[DATA_W]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCT_MERGE_CHK_EN
    logic err_q;
    logic err_evt;
    logic both_valid;

    assign both_valid = bus.i_valid0 & bus.i_valid1;
    assign err_evt    = (collecting & (mode_inv ? bus.i_valid1 : bus.i_valid0))
                      | (bus.i_start & (state != IDLE))
                      | both_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.i_start && state == IDLE) begin
            err_q <= both_valid;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_valid = fifo_valid;
    assign bus.o_data  = fifo_head[DATA_W-1:0];
    assign bus.o_last  = fifo_head[DATA_W];
    assign bus.o_afull = fifo_afull;
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_ovf   = ovf_q;

endmodule
